// File: rtl/iob_split_pkg.sv
// Shared definitions for the iob_split_pipe address splitter: bus field layout,
// width formulas and FSM state encoding.
package iob_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Request layout {valid, address, wdata, wstrb}; response layout {rdata, ready}
    localparam int WSTRB_LSB      = 0;
    localparam int RESP_READY_BIT = 0;
    localparam int RESP_RDATA_LSB = 1;

    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int wdata_lsb(input int data_w);
        return WSTRB_LSB + data_w / 8;
    endfunction

    function automatic int addr_lsb(input int data_w);
        return wdata_lsb(data_w) + data_w;
    endfunction

    function automatic int valid_bit(input int addr_w, input int data_w);
        return req_w(addr_w, data_w) - 1;
    endfunction

    function automatic int sel_w(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

endpackage

// File: rtl/iob_split_wdog.sv
// BUSY-cycle watchdog for iob_split_pipe. The counter only exists when
// IOB_SPLIT_TIMEOUT_EN is defined; otherwise expire_o is tied low.
module iob_split_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expire_o
);

`ifdef IOB_SPLIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires in the last allowed BUSY cycle so a ready arriving then still wins
    assign expire_o = count_en_i && (count_q == LAST_C);
`else
    logic unused_wdog;
    assign unused_wdog = ^{clk, rst, count_en_i, clear_i};
    assign expire_o    = 1'b0;
`endif

endmodule

// File: rtl/iob_split_pipe.sv
// One-outstanding-transaction address splitter: decodes the slave-select field,
// routes the request and muxes the response. Timeout enabled by IOB_SPLIT_TIMEOUT_EN.
module iob_split_pipe
    import iob_split_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int N_SLAVES    = 2,
    parameter int P_SLAVES    = ADDR_W - 2,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF,
    parameter int TIMEOUT_CYC = 1024,
    localparam int REQ_W      = req_w(ADDR_W, DATA_W),
    localparam int RESP_W     = resp_w(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    input  logic                       err_clr,
    output logic                       err_unmapped,
    output logic                       err_timeout
);

    localparam int SEL_W     = sel_w(N_SLAVES);
    localparam int VALID_BIT = valid_bit(ADDR_W, DATA_W);
    localparam int SEL_BIT   = addr_lsb(DATA_W) + P_SLAVES;
    localparam logic [SEL_W:0] NS_C = (SEL_W + 1)'(N_SLAVES);

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic               err_unmapped_q;
    logic               err_unmapped_d;

    logic               m_valid;
    logic [SEL_W-1:0]   m_sel;
    logic               mapped;
    logic [SEL_W-1:0]   route_sel;
    logic               fwd_en;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic               done;
    logic               busy;
    logic               expire;
    logic               timeout;
    logic               set_unmapped;

    assign m_valid = m_req[VALID_BIT];
    assign m_sel   = m_req[SEL_BIT -: SEL_W];
    assign mapped  = ({1'b0, m_sel} < NS_C);
    assign busy    = (state_q == ST_BUSY);

    // IDLE decodes the live address; BUSY sticks to the slave latched at accept
    assign route_sel = busy ? sel_q : m_sel;
    assign fwd_en    = !rst && m_valid && (busy || ((state_q == ST_IDLE) && mapped));

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (route_sel == SEL_W'(k)) begin
                sel_ready = s_resp[k*RESP_W + RESP_READY_BIT];
                sel_rdata = s_resp[k*RESP_W + RESP_RDATA_LSB +: DATA_W];
            end
        end
    end

    assign done         = fwd_en && sel_ready;
    assign timeout      = busy && expire && !sel_ready;
    assign set_unmapped = !rst && (state_q == ST_IDLE) && m_valid && !mapped;

    for (genvar k = 0; k < N_SLAVES; k++) begin : g_slv
        assign s_req[k*REQ_W +: REQ_W] =
            {fwd_en && (route_sel == SEL_W'(k)), m_req[VALID_BIT-1:0]};
    end

    always_comb begin
        m_resp = '0;
        if (!rst) begin
            if (state_q == ST_ERR) begin
                m_resp[RESP_RDATA_LSB +: DATA_W] = ERR_DATA;
                m_resp[RESP_READY_BIT]           = 1'b1;
            end else if (done) begin
                m_resp[RESP_RDATA_LSB +: DATA_W] = sel_rdata;
                m_resp[RESP_READY_BIT]           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (!mapped) begin
                            state_q <= ST_ERR;
                        end else begin
                            sel_q <= m_sel;
                            if (!done) begin
                                state_q <= ST_BUSY;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state_q <= ST_IDLE;
                    end else if (timeout) begin
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as err_clr keeps the flag high
    assign err_unmapped_d = set_unmapped ? 1'b1 : (err_clr ? 1'b0 : err_unmapped_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_unmapped_q <= 1'b0;
        end else begin
            err_unmapped_q <= err_unmapped_d;
        end
    end

    assign err_unmapped = err_unmapped_q;

    iob_split_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk        (clk),
        .rst        (rst),
        .count_en_i (busy),
        .clear_i    (!busy),
        .expire_o   (expire)
    );

`ifdef IOB_SPLIT_TIMEOUT_EN
    logic err_timeout_q;
    logic err_timeout_d;

    assign err_timeout_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_timeout_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_iob_split_pipe.sv
// Self-checking bench for iob_split_pipe (3 slaves, select in address[31:30], timeout 8).
module tb_iob_split_pipe;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NS     = 3;
    localparam int TO_CYC = 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RESP_W = DATA_W + 1;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [REQ_W-1:0]        m_req;
    logic [RESP_W-1:0]       m_resp;
    logic [NS*REQ_W-1:0]     s_req;
    logic [NS*RESP_W-1:0]    s_resp;
    logic                    err_clr;
    logic                    err_unmapped;
    logic                    err_timeout;
    logic [NS-1:0]           s_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iob_split_pipe #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .N_SLAVES    (NS),
        .P_SLAVES    (31),
        .ERR_DATA    (ERRD),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_req        (m_req),
        .m_resp       (m_resp),
        .s_req        (s_req),
        .s_resp       (s_resp),
        .err_clr      (err_clr),
        .err_unmapped (err_unmapped),
        .err_timeout  (err_timeout)
    );

    for (genvar k = 0; k < NS; k++) begin : g_v
        assign s_valid[k] = s_req[k*REQ_W + REQ_W - 1];
    end

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          lat;      // cycle the addressed slave raises ready, -1 never
        logic [31:0] srd;
        int          exp_sel;  // slave expected to see valid, -1 none
        int          exp_cyc;  // cycle of the master ready pulse
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          exp_unm;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slaves(input int target, input bit rdy, input logic [31:0] rd);
        logic        r;
        logic [31:0] d;
        for (int k = 0; k < NS; k++) begin
            if (k == target) begin
                r = rdy;
                d = rdy ? rd : $urandom;
            end else begin
                r = 1'($urandom);
                d = $urandom;
            end
            s_resp[k*RESP_W +: RESP_W] = {d, r};
        end
    endtask

    task automatic idle(input int n, input bit clr);
        for (int c = 0; c < n; c++) begin
            m_req = '0;
            m_req[REQ_W-2:0] = {$urandom, $urandom, 4'($urandom)};
            err_clr = clr && (c == 0);
            drive_slaves(-1, 1'b0, 32'h0);
            #1;
            check("idle_resp", 64'(m_resp), 64'h0);
            check("idle_valid", 64'(s_valid), 64'h0);
            step();
        end
        err_clr = 1'b0;
    endtask

    task automatic do_txn(input vec_t v, input bit clr0);
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [NS-1:0] ev;
        logic [32:0] er;
        bit          done;
        bit          bc_ok;
        wd   = $urandom;
        ws   = 4'($urandom);
        done = 1'b0;
        m_req = {1'b1, v.addr, wd, ws};
        for (int c = 0; c <= v.exp_cyc + 2 && !done; c++) begin
            err_clr = clr0 && (c == 0);
            drive_slaves(v.exp_sel, (c == v.lat), v.srd);
            #1;
            ev = (v.exp_sel >= 0 && !(v.exp_err && c == v.exp_cyc)) ? NS'(1 << v.exp_sel) : '0;
            er = (c == v.exp_cyc) ? {v.exp_rd, 1'b1} : 33'h0;
            check({v.name, ":resp"}, 64'(m_resp), 64'(er));
            check({v.name, ":valid"}, 64'(s_valid), 64'(ev));
            bc_ok = 1'b1;
            for (int k = 0; k < NS; k++)
                if (s_req[k*REQ_W +: REQ_W-1] !== m_req[REQ_W-2:0]) bc_ok = 1'b0;
            check({v.name, ":bcast"}, 64'(bc_ok), 64'h1);
            if (m_resp[0] === 1'b1) done = 1'b1;
            step();
        end
        if (!done) check({v.name, ":no_ready"}, 64'h0, 64'h1);
        m_req[REQ_W-1] = 1'b0;
        err_clr = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t rv;
    vec_t tv;
    bit   unm_model;
    int   sel;
    int   gap;
    bit   clr;
    logic [1:0] sel2;

    initial begin
        rst = 1'b1;
        m_req = '0;
        s_resp = '0;
        err_clr = 1'b0;
        vecs[0] = '{"rd_s1_lat3",   32'h4000_0010, 3,  32'h0000_1234,  1, 3, 32'h0000_1234, 1'b0, 1'b0};
        vecs[1] = '{"wr_s0_lat0",   32'h0000_0004, 0,  32'hA5A5_0001,  0, 0, 32'hA5A5_0001, 1'b0, 1'b0};
        vecs[2] = '{"rd_s2_lat1",   32'h8000_0100, 1,  32'h0BAD_F00D,  2, 1, 32'h0BAD_F00D, 1'b0, 1'b0};
        vecs[3] = '{"unmapped",     32'hC000_0000, -1, 32'h0,         -1, 1, ERRD,          1'b1, 1'b1};
        vecs[4] = '{"rd_s0_lat5",   32'h3FFF_FFFC, 5,  32'h55AA_33CC,  0, 5, 32'h55AA_33CC, 1'b0, 1'b0};
        vecs[5] = '{"s2_edge_lat8", 32'h8000_0000, 8,  32'h0000_600D,  2, 8, 32'h0000_600D, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_resp", 64'(m_resp), 64'h0);
        check("rst_valid", 64'(s_valid), 64'h0);
        check("rst_flags", 64'({err_unmapped, err_timeout}), 64'h0);
        step();

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i], 1'b0);
            check({vecs[i].name, ":unm_flag"}, 64'(err_unmapped), 64'(vecs[i].exp_unm));
            idle(1, 1'b1);
            check({vecs[i].name, ":unm_clr"}, 64'(err_unmapped), 64'h0);
        end

        // err_clr coincident with an unmapped request: set must win
        tv = '{"unm_setwins", 32'hC000_0040, -1, 32'h0, -1, 1, ERRD, 1'b1, 1'b1};
        do_txn(tv, 1'b1);
        check("setwins_flag", 64'(err_unmapped), 64'h1);
        idle(2, 1'b0);
        check("unm_sticky", 64'(err_unmapped), 64'h1);
        idle(1, 1'b1);
        check("unm_cleared", 64'(err_unmapped), 64'h0);

`ifdef IOB_SPLIT_TIMEOUT_EN
        tv = '{"timeout_s2", 32'h8000_0000, -1, 32'h0, 2, TO_CYC + 1, ERRD, 1'b1, 1'b0};
        do_txn(tv, 1'b0);
        check("timeout_flag", 64'(err_timeout), 64'h1);
        check("timeout_no_unm", 64'(err_unmapped), 64'h0);
        tv = '{"after_to_s0", 32'h0000_0100, 2, 32'hCAFE_0000, 0, 2, 32'hCAFE_0000, 1'b0, 1'b0};
        do_txn(tv, 1'b0);
        check("timeout_sticky", 64'(err_timeout), 64'h1);
        idle(1, 1'b1);
        check("timeout_clr", 64'(err_timeout), 64'h0);
`else
        tv = '{"no_timeout_s2", 32'h8000_0000, 20, 32'h0000_7777, 2, 20, 32'h0000_7777, 1'b0, 1'b0};
        do_txn(tv, 1'b0);
        check("timeout_tied", 64'(err_timeout), 64'h0);
        idle(1, 1'b0);
`endif

        // Reset in the second BUSY cycle aborts; a late slave ready is ignored
        m_req = {1'b1, 32'h4000_0000, 32'h1111_2222, 4'hF};
        for (int c = 0; c < 3; c++) begin
            drive_slaves(1, 1'b0, 32'h0);
            rst = (c == 2);
            #1;
            if (c == 2) begin
                check("midrst_resp", 64'(m_resp), 64'h0);
                check("midrst_valid", 64'(s_valid), 64'h0);
            end else begin
                check("prerst_valid", 64'(s_valid), 64'h2);
            end
            step();
        end
        rst = 1'b0;
        m_req[REQ_W-1] = 1'b0;
        s_resp = '0;
        s_resp[1*RESP_W +: RESP_W] = {32'h0000_9999, 1'b1};
        #1;
        check("postrst_resp", 64'(m_resp), 64'h0);
        check("postrst_valid", 64'(s_valid), 64'h0);
        check("postrst_flags", 64'({err_unmapped, err_timeout}), 64'h0);
        step();
        tv = '{"postrst_s0", 32'h0000_0008, 1, 32'h0000_ABCD, 0, 1, 32'h0000_ABCD, 1'b0, 1'b0};
        do_txn(tv, 1'b0);

        // Back-to-back requests with no idle gap between them
        tv = '{"b2b_s0", 32'h0000_0020, 1, 32'h0000_0A0A, 0, 1, 32'h0000_0A0A, 1'b0, 1'b0};
        do_txn(tv, 1'b0);
        tv = '{"b2b_s2", 32'h8000_0020, 0, 32'h0000_0B0B, 2, 0, 32'h0000_0B0B, 1'b0, 1'b0};
        do_txn(tv, 1'b0);
        tv = '{"b2b_s1", 32'h4000_0020, 2, 32'h0000_0C0C, 1, 2, 32'h0000_0C0C, 1'b0, 1'b0};
        do_txn(tv, 1'b0);
        idle(1, 1'b1);

        unm_model = 1'b0;
        for (int i = 0; i < 150; i++) begin
            sel  = $urandom_range(0, 3);
            sel2 = sel[1:0];
            rv.name = "rand";
            rv.addr = {sel2, 30'($urandom)};
            rv.srd  = $urandom;
            if (sel < NS) begin
                rv.lat     = $urandom_range(0, TO_CYC - 2);
                rv.exp_sel = sel;
                rv.exp_cyc = rv.lat;
                rv.exp_rd  = rv.srd;
                rv.exp_err = 1'b0;
            end else begin
                rv.lat     = -1;
                rv.exp_sel = -1;
                rv.exp_cyc = 1;
                rv.exp_rd  = ERRD;
                rv.exp_err = 1'b1;
                unm_model  = 1'b1;
            end
            rv.exp_unm = unm_model;
            do_txn(rv, 1'b0);
            check("rand_unm_flag", 64'(err_unmapped), 64'(unm_model));
            gap = $urandom_range(0, 2);
            clr = 1'($urandom);
            if (gap > 0) begin
                idle(gap, clr);
                if (clr) unm_model = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
